// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: blink/chase/bounce/count driven by a
// period/duty phase counter, with a shadow config applied only at period wrap.
module led_pattern_gen #(
  parameter int unsigned       CLK_FREQ   = 25_000_000,
  parameter int unsigned       NUM_LEDS   = 8,
  parameter int unsigned       CNT_W      = 32,
  parameter logic [CNT_W-1:0]  DEF_PERIOD = CNT_W'(CLK_FREQ),
  parameter logic [CNT_W-1:0]  DEF_DUTY   = CNT_W'(CLK_FREQ / 4)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_load,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_duty,
  input  logic [NUM_LEDS-1:0] cfg_mask,
  output logic                cfg_pending,
  output logic                period_tick,
  output logic [NUM_LEDS-1:0] leds
);

  localparam int unsigned POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  mode_e               mode_r;
  logic [CNT_W-1:0]    period_r;
  logic [CNT_W-1:0]    duty_r;
  logic [NUM_LEDS-1:0] mask_r;

  mode_e               sh_mode_r;
  logic [CNT_W-1:0]    sh_period_r;
  logic [CNT_W-1:0]    sh_duty_r;
  logic [NUM_LEDS-1:0] sh_mask_r;

  logic [CNT_W-1:0]    cnt_r;
  logic [POS_W-1:0]    pos_r;
  logic                dir_up_r;
  logic [NUM_LEDS-1:0] count_r;

  logic [CNT_W-1:0]    eff_period_s;
  logic                wrap_s;
  logic                on_s;
  logic [NUM_LEDS-1:0] onehot_s;
  logic [NUM_LEDS-1:0] pattern_s;
  logic [POS_W-1:0]    pos_nxt_s;
  logic                dir_up_nxt_s;
  logic [NUM_LEDS-1:0] count_nxt_s;

  // Phase decode: a zero period behaves as a one-cycle period.
  always_comb begin
    eff_period_s = (period_r == {CNT_W{1'b0}}) ? {{(CNT_W-1){1'b0}}, 1'b1} : period_r;
    wrap_s       = (cnt_r == (eff_period_s - {{(CNT_W-1){1'b0}}, 1'b1}));
    on_s         = (cnt_r < duty_r);
    onehot_s     = {{(NUM_LEDS-1){1'b0}}, 1'b1} << pos_r;
  end

  // Unmasked LED pattern for the current state.
  always_comb begin
    pattern_s = {NUM_LEDS{1'b0}};
    case (mode_r)
      MODE_BLINK:  pattern_s = {NUM_LEDS{on_s}};
      MODE_CHASE,
      MODE_BOUNCE: pattern_s = on_s ? onehot_s : {NUM_LEDS{1'b0}};
      MODE_COUNT:  pattern_s = on_s ? count_r : {NUM_LEDS{1'b0}};
      default:     pattern_s = {NUM_LEDS{1'b0}};
    endcase
  end

  // Pattern state to take on a plain (non-reloading) wrap.
  always_comb begin
    pos_nxt_s    = pos_r;
    dir_up_nxt_s = dir_up_r;
    count_nxt_s  = count_r;
    case (mode_r)
      MODE_CHASE: begin
        if (pos_r == POS_LAST) begin
          pos_nxt_s = {POS_W{1'b0}};
        end else begin
          pos_nxt_s = pos_r + {{(POS_W-1){1'b0}}, 1'b1};
        end
      end
      MODE_BOUNCE: begin
        // Turn around on the endpoint itself so no endpoint is shown twice.
        if (dir_up_r) begin
          if (pos_r == POS_LAST) begin
            dir_up_nxt_s = 1'b0;
            pos_nxt_s    = pos_r - {{(POS_W-1){1'b0}}, 1'b1};
          end else begin
            pos_nxt_s    = pos_r + {{(POS_W-1){1'b0}}, 1'b1};
          end
        end else begin
          if (pos_r == {POS_W{1'b0}}) begin
            dir_up_nxt_s = 1'b1;
            pos_nxt_s    = pos_r + {{(POS_W-1){1'b0}}, 1'b1};
          end else begin
            pos_nxt_s    = pos_r - {{(POS_W-1){1'b0}}, 1'b1};
          end
        end
      end
      MODE_COUNT: count_nxt_s = count_r + {{(NUM_LEDS-1){1'b0}}, 1'b1};
      default: begin
        pos_nxt_s    = pos_r;
        dir_up_nxt_s = dir_up_r;
        count_nxt_s  = count_r;
      end
    endcase
  end

  // Counter, config shadow/apply, pattern state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r      <= MODE_BLINK;
      period_r    <= DEF_PERIOD;
      duty_r      <= DEF_DUTY;
      mask_r      <= {NUM_LEDS{1'b1}};
      sh_mode_r   <= MODE_BLINK;
      sh_period_r <= DEF_PERIOD;
      sh_duty_r   <= DEF_DUTY;
      sh_mask_r   <= {NUM_LEDS{1'b1}};
      cnt_r       <= {CNT_W{1'b0}};
      pos_r       <= {POS_W{1'b0}};
      dir_up_r    <= 1'b1;
      count_r     <= {NUM_LEDS{1'b0}};
      cfg_pending <= 1'b0;
      period_tick <= 1'b0;
      leds        <= {NUM_LEDS{1'b0}};
    end else begin
      period_tick <= wrap_s;
      leds        <= mask_r & pattern_s;

      if (wrap_s) begin
        cnt_r <= {CNT_W{1'b0}};
        if (cfg_pending) begin
          mode_r   <= sh_mode_r;
          period_r <= sh_period_r;
          duty_r   <= sh_duty_r;
          mask_r   <= sh_mask_r;
          if (sh_mode_r != mode_r) begin
            pos_r    <= {POS_W{1'b0}};
            dir_up_r <= 1'b1;
            count_r  <= {NUM_LEDS{1'b0}};
          end
        end else begin
          pos_r    <= pos_nxt_s;
          dir_up_r <= dir_up_nxt_s;
          count_r  <= count_nxt_s;
        end
      end else begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      // A load coinciding with a wrap only refills the shadow.
      if (cfg_load) begin
        sh_mode_r   <= mode_e'(cfg_mode);
        sh_period_r <= cfg_period;
        sh_duty_r   <= cfg_duty;
        sh_mask_r   <= cfg_mask;
        cfg_pending <= 1'b1;
      end else if (wrap_s) begin
        cfg_pending <= 1'b0;
      end
    end
  end

endmodule
